// File: rtl/mainbus_arbiter.sv
// mainbus_arbiter
//   Primary-side sequencer for the shared main bus. Grants one of NUM_REQ
//   requesters round-robin and runs a single 4-beat burst: one address phase
//   followed by four data beats on the multiplexed bus_AddrData. Reads get an
//   extra TURN cycle so the secondary's last drive clears before the next
//   address goes out.
// Ports
//   clk, resetL            clock, asynchronous active-low reset
//   req/req_rw/req_addr    per-requester request, direction (1 = read), start address
//   req_wdata              per-requester write word for the current beat
//   grant                  one-hot grant, ADDR through D4
//   beat, data_phase       data-beat index and D1..D4 indicator
//   rdata/_valid/_beat     registered read word, one-cycle valid, its beat index
//   done                   one-cycle completion pulse to the granted requester
//   bus_AddrValid, bus_rw  address strobe and burst direction
//   bus_AddrData           bidirectional address/data, Z when not driven here
module mainbus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DW      = 16
) (
  input  logic                  clk,
  input  logic                  resetL,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    req_rw,
  input  logic [NUM_REQ*DW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    grant,
  output logic [1:0]            beat,
  output logic                  data_phase,
  output logic [DW-1:0]         rdata,
  output logic                  rdata_valid,
  output logic [1:0]            rdata_beat,
  output logic [NUM_REQ-1:0]    done,
  output logic                  bus_AddrValid,
  output logic                  bus_rw,
  inout  wire  [DW-1:0]         bus_AddrData
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned SumW = IdxW + 1;

  typedef enum logic [2:0] {StIdle, StAddr, StD1, StD2, StD3, StD4, StTurn} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    win_q, win_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic               rw_q, rw_d;
  logic [DW-1:0]      addr_q, addr_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               rdata_valid_q, rdata_valid_d;
  logic [1:0]         rdata_beat_q, rdata_beat_d;
  logic [NUM_REQ-1:0] done_q, done_d;

  logic               found;
  logic [IdxW-1:0]    pick;
  logic [SumW-1:0]    cand;
  logic               in_data;
  logic [1:0]         beat_c;
  logic               drive_en;
  logic [DW-1:0]      drive_val;

  // Round-robin search starting just after the previous winner, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_q} + SumW'(i);
      if (cand >= SumW'(NUM_REQ)) cand = cand - SumW'(NUM_REQ);
      if (!found && req[cand[IdxW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    in_data = 1'b0;
    beat_c  = 2'd0;
    unique case (state_q)
      StD1:    begin in_data = 1'b1; beat_c = 2'd0; end
      StD2:    begin in_data = 1'b1; beat_c = 2'd1; end
      StD3:    begin in_data = 1'b1; beat_c = 2'd2; end
      StD4:    begin in_data = 1'b1; beat_c = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    last_d        = last_q;
    rw_d          = rw_q;
    addr_d        = addr_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    rdata_beat_d  = rdata_beat_q;
    done_d        = '0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          last_d  = pick;
          rw_d    = req_rw[pick];
          addr_d  = req_addr[32'(pick) * DW +: DW];
          state_d = StAddr;
        end
      end
      StAddr: state_d = StD1;
      StD1:   state_d = StD2;
      StD2:   state_d = StD3;
      StD3:   state_d = StD4;
      StD4: begin
        done_d[win_q] = 1'b1;
        state_d       = rw_q ? StTurn : StIdle;
      end
      StTurn:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Read data is taken straight off the pins at the edge closing each beat.
    if (in_data && rw_q) begin
      rdata_d       = bus_AddrData;
      rdata_beat_d  = beat_c;
      rdata_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state_q       <= StIdle;
      win_q         <= '0;
      last_q        <= IdxW'(NUM_REQ - 1);
      rw_q          <= 1'b1;
      addr_q        <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_beat_q  <= 2'd0;
      done_q        <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      last_q        <= last_d;
      rw_q          <= rw_d;
      addr_q        <= addr_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_beat_q  <= rdata_beat_d;
      done_q        <= done_d;
    end
  end

  // Drive only in ADDR and in write data beats; state resets to IDLE, so the
  // pins float as soon as resetL falls.
  assign drive_en  = (state_q == StAddr) || (in_data && !rw_q);
  assign drive_val = (state_q == StAddr) ? addr_q : req_wdata[32'(win_q) * DW +: DW];
  assign bus_AddrData = drive_en ? drive_val : {DW{1'bz}};

  assign grant         = ((state_q == StAddr) || in_data) ? (NUM_REQ'(1) << win_q) : '0;
  assign beat          = beat_c;
  assign data_phase    = in_data;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign rdata_beat    = rdata_beat_q;
  assign done          = done_q;
  assign bus_AddrValid = (state_q == StAddr);
  assign bus_rw        = rw_q;

endmodule

// File: tb/tb_mainbus_arbiter.sv
// Testbench for mainbus_arbiter: a page-2 memory secondary on the bus, a probe
// driver used to show the arbiter has released the pins, and per-scenario tasks
// that queue expected bus words / read results and compare as the DUT emits them.
module tb_mainbus_arbiter;
  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DW      = 16;
  localparam logic [DW-1:0] PROBE = 16'h5A5A;

  typedef struct packed {
    logic [1:0]    beat;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic                  clk = 1'b0;
  logic                  resetL = 1'b0;
  logic [NUM_REQ-1:0]    req, req_rw;
  logic [NUM_REQ*DW-1:0] req_addr, req_wdata;
  logic [NUM_REQ-1:0]    grant, done;
  logic [1:0]            beat, rdata_beat;
  logic                  data_phase, rdata_valid, bus_AddrValid, bus_rw;
  logic [DW-1:0]         rdata;
  wire  [DW-1:0]         bus_ad;

  logic [DW-1:0] wtab [NUM_REQ][4];
  logic          probe_en;
  int            n_vec = 0;
  int            n_err = 0;

  logic [DW-1:0] bus_q [$];
  rd_exp_t       rd_q [$];
  logic [NUM_REQ-1:0] gnt_q [$];

  always #5 clk = ~clk;

  mainbus_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
    .clk          (clk),
    .resetL       (resetL),
    .req          (req),
    .req_rw       (req_rw),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .grant        (grant),
    .beat         (beat),
    .data_phase   (data_phase),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .rdata_beat   (rdata_beat),
    .done         (done),
    .bus_AddrValid(bus_AddrValid),
    .bus_rw       (bus_rw),
    .bus_AddrData (bus_ad)
  );

  // Requesters present the word for the current beat.
  always_comb begin
    req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) req_wdata[i*DW +: DW] = wtab[i][beat];
  end

  // Page-2 memory secondary: latches the address on AddrValid, then four beats.
  int            sec_k;
  logic          sec_rw;
  logic [DW-1:0] sec_addr, sec_data;
  logic          sec_drv;
  logic [DW-1:0] mem [256];

  always @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      sec_k <= 0;
    end else if (bus_AddrValid) begin
      sec_addr <= bus_ad;
      sec_rw   <= bus_rw;
      sec_k    <= 1;
    end else if (sec_k != 0) begin
      if (!sec_rw && sec_addr[15:12] == 4'h2) mem[sec_addr[7:0] + 8'(sec_k - 1)] <= bus_ad;
      sec_k <= (sec_k == 4) ? 0 : sec_k + 1;
    end
  end

  always_comb begin
    sec_drv  = (sec_k != 0) && sec_rw && (sec_addr[15:12] == 4'h2);
    sec_data = mem[sec_addr[7:0] + 8'(sec_k - 1)];
  end

  assign bus_ad = sec_drv ? sec_data : {DW{1'bz}};
  assign bus_ad = probe_en ? PROBE : {DW{1'bz}};

  task automatic wait_done(input int idx, output int cyc);
    cyc = -1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (done[idx]) begin
        cyc = n;
        req[idx] = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    probe_en = 1'b0;
    req = '0; req_rw = '0; req_addr = '0;
    resetL = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({grant, done, rdata_valid, bus_AddrValid, data_phase} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b want 0000000",
               {grant, done, rdata_valid, bus_AddrValid, data_phase});
    end
    n_vec++;
    if ({bus_rw, beat, rdata} !== {1'b1, 2'd0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_data: got rw=%b beat=%0d rdata=%h want rw=1 beat=0 rdata=0000",
               bus_rw, beat, rdata);
    end
    probe_en = 1'b1; #1;
    n_vec++;
    if (bus_ad !== PROBE) begin
      n_err++;
      $display("FAIL reset_bus_release: got %h want %h", bus_ad, PROBE);
    end
    probe_en = 1'b0;
    resetL = 1'b1;
  endtask

  task automatic test_write();
    logic [DW-1:0] w;
    bus_q.push_back(16'h2010);
    for (int k = 0; k < 4; k++) begin
      wtab[0][k] = 16'hA0A0 + 16'(k) * 16'h0101;
      bus_q.push_back(wtab[0][k]);
    end
    req_rw[0] = 1'b0; req_addr[0 +: DW] = 16'h2010; req[0] = 1'b1;
    @(negedge clk);
    w = bus_q.pop_front();
    n_vec++;
    if ({bus_AddrValid, grant, bus_rw, bus_ad} !== {1'b1, 2'b01, 1'b0, w}) begin
      n_err++;
      $display("FAIL wr_addr: got av=%b gnt=%b rw=%b bus=%h want av=1 gnt=01 rw=0 bus=%h",
               bus_AddrValid, grant, bus_rw, bus_ad, w);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      w = bus_q.pop_front();
      n_vec++;
      if ({bus_AddrValid, data_phase, beat, grant, bus_ad} !== {2'b01, 2'(k), 2'b01, w}) begin
        n_err++;
        $display("FAIL wr_beat%0d: got av=%b dp=%b beat=%0d gnt=%b bus=%h want bus=%h",
                 k, bus_AddrValid, data_phase, beat, grant, bus_ad, w);
      end
    end
    @(negedge clk);
    n_vec++;
    if ({done, grant, data_phase} !== {2'b01, 2'b00, 1'b0}) begin
      n_err++;
      $display("FAIL wr_done: got done=%b gnt=%b dp=%b want done=01 gnt=00 dp=0",
               done, grant, data_phase);
    end
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (mem[8'h10 + 8'(k)] !== 16'hA0A0 + 16'(k) * 16'h0101) begin
        n_err++;
        $display("FAIL wr_mem%0d: got %h want %h", k, mem[8'h10 + 8'(k)],
                 16'hA0A0 + 16'(k) * 16'h0101);
      end
    end
  endtask

  task automatic test_read();
    logic [DW-1:0] w;
    rd_exp_t       e;
    int            n_rv;
    n_rv = 0;
    for (int k = 0; k < 4; k++) begin
      bus_q.push_back(16'hA0A0 + 16'(k) * 16'h0101);
      rd_q.push_back({2'(k), 16'hA0A0 + 16'(k) * 16'h0101});
    end
    req_rw[1] = 1'b1; req_addr[DW +: DW] = 16'h2010; req[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_vec++;
        if ({bus_AddrValid, grant, bus_rw, bus_ad} !== {1'b1, 2'b10, 1'b1, 16'h2010}) begin
          n_err++;
          $display("FAIL rd_addr: got av=%b gnt=%b rw=%b bus=%h want av=1 gnt=10 rw=1 bus=2010",
                   bus_AddrValid, grant, bus_rw, bus_ad);
        end
      end else if (c <= 5) begin
        w = bus_q.pop_front();
        n_vec++;
        if ({data_phase, beat, grant, bus_ad} !== {1'b1, 2'(c - 2), 2'b10, w}) begin
          n_err++;
          $display("FAIL rd_beat%0d: got dp=%b beat=%0d gnt=%b bus=%h want bus=%h",
                   c - 2, data_phase, beat, grant, bus_ad, w);
        end
      end
      n_vec++;
      if (rdata_valid !== (c >= 3 && c <= 6)) begin
        n_err++;
        $display("FAIL rd_valid_c%0d: got %b want %b", c, rdata_valid, (c >= 3 && c <= 6));
      end
      if (rdata_valid && rd_q.size() != 0) begin
        e = rd_q.pop_front();
        n_vec++;
        if ({rdata_beat, rdata} !== e) begin
          n_err++;
          $display("FAIL rd_data: got beat=%0d data=%h want beat=%0d data=%h",
                   rdata_beat, rdata, e.beat, e.data);
        end
        n_rv++;
      end
      if (c == 6) begin
        n_vec++;
        if ({done, grant, data_phase, bus_AddrValid} !== {2'b10, 2'b00, 2'b00}) begin
          n_err++;
          $display("FAIL rd_done: got done=%b gnt=%b dp=%b av=%b want done=10 gnt=00 dp=0 av=0",
                   done, grant, data_phase, bus_AddrValid);
        end
        probe_en = 1'b1; #1;
        n_vec++;
        if (bus_ad !== PROBE) begin
          n_err++;
          $display("FAIL rd_turn_release: got %h want %h", bus_ad, PROBE);
        end
        probe_en = 1'b0;
        req[1] = 1'b0;
      end
      if (c >= 7) begin
        n_vec++;
        if (bus_AddrValid !== 1'b0) begin
          n_err++;
          $display("FAIL rd_idle_c%0d: got av=%b want 0", c, bus_AddrValid);
        end
      end
    end
    n_vec++;
    if (n_rv != 4) begin
      n_err++;
      $display("FAIL rd_count: got %0d pulses want 4", n_rv);
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_REQ-1:0] cur;
    int                 n_done;
    cur = '0; n_done = 0;
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    gnt_q.push_back(2'b01); gnt_q.push_back(2'b10);
    for (int k = 0; k < 4; k++) begin
      wtab[0][k] = 16'h1100 + 16'(k);
      wtab[1][k] = 16'h2200 + 16'(k);
    end
    req_rw = 2'b00; req_addr = {16'h3100, 16'h3000}; req = 2'b11;
    for (int c = 1; c <= 40 && n_done < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (!$onehot0(grant)) begin
        n_err++;
        $display("FAIL rr_onehot: got %b want at most one bit", grant);
      end
      if (bus_AddrValid) begin
        cur = (gnt_q.size() != 0) ? gnt_q.pop_front() : 2'b00;
        n_vec++;
        if (grant !== cur) begin
          n_err++;
          $display("FAIL rr_grant: got %b want %b", grant, cur);
        end
      end
      if (done != 2'b00) begin
        n_vec++;
        if (done !== cur) begin
          n_err++;
          $display("FAIL rr_done: got %b want %b", done, cur);
        end
        n_done++;
        if (n_done == 4) req = 2'b00;
      end
    end
    n_vec++;
    if (n_done != 4 || gnt_q.size() != 0) begin
      n_err++;
      $display("FAIL rr_count: got done=%0d left=%0d want done=4 left=0", n_done, gnt_q.size());
    end
    req = 2'b00;
  endtask

  task automatic test_back_to_back();
    int      addr_t[3];
    int      d4_t[3];
    int      n_addr, n_d4, n_done;
    rd_exp_t e;
    n_addr = 0; n_d4 = 0; n_done = 0;
    addr_t = '{default: 0}; d4_t = '{default: 0};
    for (int k = 0; k < 4; k++) begin
      wtab[0][k] = 16'hB0B0 + 16'(k) * 16'h0101;
      rd_q.push_back({2'(k), 16'hB0B0 + 16'(k) * 16'h0101});
    end
    req_rw[0] = 1'b0; req_addr[0 +: DW] = 16'h2020; req[0] = 1'b1;
    for (int c = 1; c <= 40 && n_done < 3; c++) begin
      @(negedge clk);
      if (bus_AddrValid && n_addr < 3) begin addr_t[n_addr] = c; n_addr++; end
      if (data_phase && beat == 2'd3 && n_d4 < 3) begin d4_t[n_d4] = c; n_d4++; end
      if (sec_drv) begin
        n_vec++;
        if (bus_ad !== sec_data) begin
          n_err++;
          $display("FAIL b2b_contention_c%0d: got %h want %h", c, bus_ad, sec_data);
        end
      end
      if (rdata_valid) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_rd_extra: got beat=%0d data=%h want none", rdata_beat, rdata);
        end else begin
          e = rd_q.pop_front();
          if ({rdata_beat, rdata} !== e) begin
            n_err++;
            $display("FAIL b2b_rd_data: got beat=%0d data=%h want beat=%0d data=%h",
                     rdata_beat, rdata, e.beat, e.data);
          end
        end
      end
      if (done[0]) begin
        n_done++;
        if (n_done == 1) begin
          req_rw[0] = 1'b1;
        end else if (n_done == 2) begin
          req_rw[0] = 1'b0;
          req_addr[0 +: DW] = 16'h3000;
        end else begin
          req[0] = 1'b0;
        end
      end
    end
    n_vec++;
    if (n_done != 3 || n_addr != 3) begin
      n_err++;
      $display("FAIL b2b_count: got done=%0d addr=%0d want 3 and 3", n_done, n_addr);
    end
    n_vec++;
    if (addr_t[1] - d4_t[0] != 2) begin
      n_err++;
      $display("FAIL b2b_wr_gap: got %0d want 2", addr_t[1] - d4_t[0]);
    end
    n_vec++;
    if (addr_t[2] - d4_t[1] != 3) begin
      n_err++;
      $display("FAIL b2b_rd_gap: got %0d want 3", addr_t[2] - d4_t[1]);
    end
    n_vec++;
    if (rd_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_rd_missing: got %0d left want 0", rd_q.size());
    end
    req = 2'b00;
  endtask

  task automatic test_req_drop();
    int n_d34;
    n_d34 = 0;
    for (int k = 0; k < 4; k++) wtab[0][k] = 16'hD000 + 16'(k);
    req_rw[0] = 1'b0; req_addr[0 +: DW] = 16'h3040; req[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (data_phase && beat == 2'd1) req[0] = 1'b0;
      if (data_phase && beat >= 2'd2) begin
        n_d34++;
        n_vec++;
        if ({grant, bus_ad} !== {2'b01, wtab[0][beat]}) begin
          n_err++;
          $display("FAIL drop_beat%0d: got gnt=%b bus=%h want gnt=01 bus=%h",
                   beat, grant, bus_ad, wtab[0][beat]);
        end
      end
      if (c == 6) begin
        n_vec++;
        if (done !== 2'b01) begin
          n_err++;
          $display("FAIL drop_done: got %b want 01", done);
        end
      end
      if (c >= 7) begin
        n_vec++;
        if ({bus_AddrValid, grant} !== 3'b000) begin
          n_err++;
          $display("FAIL drop_restart_c%0d: got av=%b gnt=%b want 0 00", c, bus_AddrValid, grant);
        end
      end
    end
    n_vec++;
    if (n_d34 != 2) begin
      n_err++;
      $display("FAIL drop_beats: got %0d late beats want 2", n_d34);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    for (int k = 0; k < 4; k++) wtab[0][k] = 16'hC0C0 + 16'(k);
    req_rw = 2'b00; req_addr = {16'h3200, 16'h2030}; req = 2'b01;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({data_phase, beat} !== {1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL rst_mid_pre: got dp=%b beat=%0d want dp=1 beat=1", data_phase, beat);
    end
    #2 resetL = 1'b0;
    #1;
    n_vec++;
    if ({grant, done, data_phase, bus_AddrValid, bus_rw, beat} !== {4'b0000, 2'b00, 1'b1, 2'd0})
    begin
      n_err++;
      $display("FAIL rst_mid_async: got gnt=%b done=%b dp=%b av=%b rw=%b beat=%0d",
               grant, done, data_phase, bus_AddrValid, bus_rw, beat);
    end
    probe_en = 1'b1; #1;
    n_vec++;
    if (bus_ad !== PROBE) begin
      n_err++;
      $display("FAIL rst_mid_release: got %h want %h", bus_ad, PROBE);
    end
    probe_en = 1'b0;
    req = 2'b11;
    @(negedge clk);
    n_vec++;
    if ({done, grant, rdata_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_mid_nodone: got done=%b gnt=%b rv=%b want 0", done, grant, rdata_valid);
    end
    resetL = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus_AddrValid, grant} !== {1'b1, 2'b01}) begin
      n_err++;
      $display("FAIL rst_mid_first: got av=%b gnt=%b want av=1 gnt=01", bus_AddrValid, grant);
    end
    req[1] = 1'b0;
    wait_done(0, cyc);
    n_vec++;
    if (cyc != 5) begin
      n_err++;
      $display("FAIL rst_mid_finish: got done after %0d cycles want 5", cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mainbus_arbiter.md
Name: mainbus_arbiter

Overview:
- Primary-side sequencer for the shared main bus. It arbitrates between NUM_REQ client requesters and runs one 4-beat burst at a time.
- Each burst is one address phase (AddrValid, rw, AddrData=address) followed by four data beats on the bidirectional AddrData, matching the page-decoded memory secondaries on the bus.
- Arbitration is round-robin. The block sits between the CPU-side clients and the bus pins.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DW, 16, bus address/data width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetL  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester burst request; held high until that requester's done pulse.
- req_rw  input  NUM_REQ  per-requester direction: 1 = read, 0 = write.
- req_addr  input  NUM_REQ*DW  per-requester start address; slice i is bits [i*DW +: DW].
- req_wdata  input  NUM_REQ*DW  per-requester write word for the current beat.
- grant  output  NUM_REQ  one-hot; the granted requester, high from ADDR through D4.
- beat  output  2  current data-beat index, 0..3. Valid while data_phase=1.
- data_phase  output  1  high during D1..D4.
- rdata  output  DW  registered read word.
- rdata_valid  output  1  one-cycle pulse: rdata holds beat rdata_beat of the granted read.
- rdata_beat  output  2  beat index of rdata.
- done  output  NUM_REQ  one-cycle pulse to the requester whose burst just finished.
- bus_AddrValid  output  1  address-phase strobe.
- bus_rw  output  1  direction of the current burst.
- bus_AddrData  inout  DW  multiplexed address/data; high-Z when this block is not driving.

Behaviour:
- Reset (resetL=0, asynchronous):
  - state=IDLE; grant, done, rdata_valid, bus_AddrValid, data_phase = 0.
  - bus_rw=1; beat=0; rdata=0; round-robin pointer last=NUM_REQ-1.
  - bus_AddrData released to Z immediately.
  - Reset mid-burst abandons the burst with no done pulse.
- States: IDLE, ADDR, D1, D2, D3, D4, TURN.
- IDLE:
  - If any req bit is set, pick the winner by searching from index last+1 upward, wrapping at NUM_REQ.
  - Latch the winner's index, req_rw and req_addr. Set last = winner. Go to ADDR.
  - Otherwise stay in IDLE.
- ADDR (1 cycle):
  - bus_AddrValid=1, bus_rw=latched rw, bus_AddrData driven with the latched address, grant[winner]=1.
  - Next state is D1.
- D1..D4 (1 cycle each):
  - data_phase=1, beat=0..3, bus_AddrValid=0, grant held, bus_rw held.
  - Write burst: bus_AddrData is driven combinationally from req_wdata slice [winner] during every Dk. The requester presents word `beat` in the same cycle.
  - Read burst: bus_AddrData = Z. At the rising edge ending Dk, capture rdata <= bus_AddrData and rdata_beat <= k-1, and pulse rdata_valid in the following cycle. Four pulses with rdata_beat 0,1,2,3 appear in the cycles after D1..D4.
  - D4 exit: write goes to IDLE, read goes to TURN. In both cases done[winner] pulses for one cycle in the cycle after D4, and grant drops in that cycle.
- TURN (1 cycle, reads only):
  - Bus is Z and no arbitration happens, so the secondary's D4 drive cannot contend with the next address.
  - Next state is IDLE.
- Throughput: a write burst takes 6 cycles (IDLE..D4); a read burst takes 7 cycles.
- Requests and mid-burst changes:
  - A req that drops mid-burst is ignored and the burst completes.
  - The same requester may re-request in the cycle after done.
  - New reqs arriving mid-burst wait for IDLE.
- Unmapped pages: the block has no page knowledge. A read to an unmapped page returns whatever is on the floating bus (X/Z). A bus pull-up, if present, is outside this block.
- Contention guarantee: the block never drives bus_AddrData in D1..D4 of a read, in TURN, or in IDLE.
- Single requester: last still updates, so a lone requester is served every burst.

Test Plan:
- Reset: resetL=0 mid-D2 of a write -> outputs at reset values within the same cycle, bus_AddrData=Z, no done pulse. After release, req0 wins first.
- Single write: req[0]=1, rw=0, addr=16'h2010, wdata beats A0A0,A1A1,A2A2,A3A3 -> ADDR drives 2010 with AddrValid=1, D1..D4 drive the four words in order, done[0] pulses 5 cycles after ADDR. A later read of 2010 returns the same words.
- Single read: req[1]=1, rw=1, addr=16'h2010 with a page-2 memory preloaded -> rdata_valid pulses 4 consecutive cycles, rdata_beat 0..3 with data A0A0..A3A3. TURN follows D4 and the bus is Z in TURN.
- Round-robin: req=2'b11 held continuously -> grant order 0,1,0,1. Each done pulse matches its grant, and there is never more than one grant bit high.
- Back-to-back write then read from the same requester, re-request in the done cycle -> next ADDR begins exactly 1 IDLE cycle after D4. Checker asserts no cycle with both this block and the secondary driving bus_AddrData.
- Request dropped: req[0] deasserted during D2 -> burst completes through D4 and done[0] still pulses.
